// File: rtl/tt_pkg.sv
// Shared constants for the tinytester phase sequencer: one-hot state bit
// positions, state vector width and default field widths.
package tt_pkg;

  localparam int STATE_W = 7;

  localparam int ST_P0      = 0;
  localparam int ST_P1      = 1;
  localparam int ST_P2      = 2;
  localparam int ST_P3      = 3;
  localparam int ST_CAPTURE = 4;
  localparam int ST_WAIT    = 5;
  localparam int ST_IDLE    = 6;

  localparam int PL_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef logic [STATE_W-1:0] state_t;

endpackage

// File: rtl/tt_phase_timer.sv
// Loadable down-counter shared by all four drive phases; tc is high while the
// count is zero, so a load of L gives L+1 cycles before tc.
module tt_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/tt_phase_sequencer.sv
// Drives each accepted vector through phases P0..P3 and a capture cycle.
// Outputs are registered from the next state; vec_ready_o is high only in WAIT.
module tt_phase_sequencer
  import tt_pkg::*;
#(
  parameter int NPINS = 32,
  parameter int PL_W  = PL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [PL_W-1:0]    phase_len_i,
  input  logic [CNT_W-1:0]   vec_count_i,
  input  logic               vec_valid_i,
  output logic               vec_ready_o,
  input  logic [NPINS-1:0]   dataout_i,
  input  logic [NPINS-1:0]   oe_i,
  input  logic [NPINS-1:0]   active_on_p0_i,
  input  logic [NPINS-1:0]   active_on_p1_i,
  input  logic [NPINS-1:0]   active_on_p2_i,
  input  logic [NPINS-1:0]   active_on_p3_i,
  output logic [NPINS-1:0]   padout_o,
  output logic [NPINS-1:0]   padoe_o,
  input  logic [NPINS-1:0]   padin_i,
  output logic [NPINS-1:0]   result_o,
  output logic               result_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   done_cnt_o,
  output logic [STATE_W-1:0] sequencer_state
);

  localparam logic [STATE_W-1:0] S_P0   = STATE_W'(1 << ST_P0);
  localparam logic [STATE_W-1:0] S_P1   = STATE_W'(1 << ST_P1);
  localparam logic [STATE_W-1:0] S_P2   = STATE_W'(1 << ST_P2);
  localparam logic [STATE_W-1:0] S_P3   = STATE_W'(1 << ST_P3);
  localparam logic [STATE_W-1:0] S_CAP  = STATE_W'(1 << ST_CAPTURE);
  localparam logic [STATE_W-1:0] S_WAIT = STATE_W'(1 << ST_WAIT);
  localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(1 << ST_IDLE);

  state_t             state_q;
  state_t             state_nxt;
  logic [PL_W-1:0]    len_q;
  logic [CNT_W-1:0]   count_q;
  logic [NPINS-1:0]   vec_data_q;
  logic [NPINS-1:0]   vec_oe_q;
  logic [NPINS-1:0]   vec_data_nxt;
  logic [NPINS-1:0]   vec_oe_nxt;
  logic [NPINS-1:0]   padout_nxt;
  logic [NPINS-1:0]   padoe_nxt;
  logic [CNT_W-1:0]   done_cnt_inc;
  logic               tc;
  logic               timer_load;
  logic               hs;
  logic               start_go;
  logic               cap_exit;
  logic               last_vec;

  assign sequencer_state = state_q;

  assign hs       = (state_q == S_WAIT) && vec_valid_i && vec_ready_o && !abort_i;
  assign start_go = (state_q == S_IDLE) && start_i && !abort_i;
  assign cap_exit = (state_q == S_CAP) && !abort_i;

  // Saturating completion count; the run ends when it reaches a nonzero target.
  assign done_cnt_inc = (&done_cnt_o) ? done_cnt_o : done_cnt_o + 1'b1;
  assign last_vec     = (count_q != '0) && (done_cnt_inc == count_q);

  assign vec_data_nxt = hs ? dataout_i : vec_data_q;
  assign vec_oe_nxt   = hs ? oe_i      : vec_oe_q;

  assign timer_load = (state_nxt != state_q) && (|state_nxt[ST_P3:ST_P0]);

  tt_phase_timer #(
    .W (PL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (len_q),
    .tc       (tc)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_nxt = S_WAIT;
      S_WAIT:  if (vec_valid_i && vec_ready_o) state_nxt = S_P0;
      S_P0:    if (tc) state_nxt = S_P1;
      S_P1:    if (tc) state_nxt = S_P2;
      S_P2:    if (tc) state_nxt = S_P3;
      S_P3:    if (tc) state_nxt = S_CAP;
      S_CAP:   state_nxt = last_vec ? S_IDLE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_i) begin
      state_nxt = S_IDLE;
    end
  end

  // Pads are computed from the next state so they change on the same edge.
  always_comb begin
    padout_nxt = '0;
    padoe_nxt  = '0;
    case (state_nxt)
      S_P0: begin
        padout_nxt = vec_data_nxt & active_on_p0_i;
        padoe_nxt  = vec_oe_nxt;
      end
      S_P1: begin
        padout_nxt = vec_data_nxt & active_on_p1_i;
        padoe_nxt  = vec_oe_nxt;
      end
      S_P2: begin
        padout_nxt = vec_data_nxt & active_on_p2_i;
        padoe_nxt  = vec_oe_nxt;
      end
      S_P3: begin
        padout_nxt = vec_data_nxt & active_on_p3_i;
        padoe_nxt  = vec_oe_nxt;
      end
      S_CAP: begin
        padout_nxt = padout_o;
        padoe_nxt  = padoe_o;
      end
      default: begin
        padout_nxt = '0;
        padoe_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      count_q        <= '0;
      vec_data_q     <= '0;
      vec_oe_q       <= '0;
      padout_o       <= '0;
      padoe_o        <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      done_o         <= 1'b0;
      done_cnt_o     <= '0;
      vec_ready_o    <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      vec_data_q     <= vec_data_nxt;
      vec_oe_q       <= vec_oe_nxt;
      padout_o       <= padout_nxt;
      padoe_o        <= padoe_nxt;
      vec_ready_o    <= (state_nxt == S_WAIT);
      busy_o         <= (state_nxt != S_IDLE);
      result_valid_o <= cap_exit;
      done_o         <= cap_exit && last_vec;
      if (cap_exit) begin
        result_o   <= padin_i;
        done_cnt_o <= done_cnt_inc;
      end
      if (start_go) begin
        len_q      <= phase_len_i;
        count_q    <= vec_count_i;
        done_cnt_o <= '0;
      end
    end
  end

endmodule
